// File: rtl/pipe_pkg.sv
// Shared definitions for the execute stage: datapath widths, ALU and condition
// codes, the condition-code register layout and its reset value, plus the
// branch-condition evaluation helper.
package pipe_pkg;

  localparam int unsigned W     = 64;
  localparam int unsigned DST_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    C_ALWAYS = 3'd0,
    C_LE     = 3'd1,
    C_L      = 3'd2,
    C_E      = 3'd3,
    C_NE     = 3'd4,
    C_GE     = 3'd5,
    C_G      = 3'd6,
    C_RSVD   = 3'd7
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CcReset = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Branch condition from a condition-code snapshot.
  function automatic logic eval_cond(cond_e cfun, cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (cfun)
      C_ALWAYS: eval_cond = 1'b1;
      C_LE:     eval_cond = lt | cc.zf;
      C_L:      eval_cond = lt;
      C_E:      eval_cond = cc.zf;
      C_NE:     eval_cond = ~cc.zf;
      C_GE:     eval_cond = ~lt;
      C_G:      eval_cond = ~lt & ~cc.zf;
      default:  eval_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Purely combinational W-bit ALU computing r = b OP a with zero, sign and
// signed-overflow flags.
// Ports:
//   op_i  : ALU operation (ADD, SUB, AND, XOR)
//   a_i   : operand A
//   b_i   : operand B
//   r_o   : result (wraps at W bits)
//   zf_o  : result is zero
//   sf_o  : result sign bit
//   of_o  : signed overflow (ADD/SUB only, 0 for logic ops)
module alu_core_comb
  import pipe_pkg::*;
(
  input  alu_op_e        op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W-1:0]   r_o,
  output logic           zf_o,
  output logic           sf_o,
  output logic           of_o
);

  logic sa, sb, sr;

  always_comb begin
    r_o = '0;
    unique case (op_i)
      ALU_ADD: r_o = b_i + a_i;
      ALU_SUB: r_o = b_i - a_i;
      ALU_AND: r_o = b_i & a_i;
      ALU_XOR: r_o = b_i ^ a_i;
      default: r_o = '0;
    endcase
  end

  assign sa = a_i[W-1];
  assign sb = b_i[W-1];
  assign sr = r_o[W-1];

  // Overflow when the result sign disagrees with B although A could not
  // have pulled it there legitimately.
  always_comb begin
    of_o = 1'b0;
    unique case (op_i)
      ALU_ADD: of_o = (sa == sb) && (sr != sb);
      ALU_SUB: of_o = (sa != sb) && (sr != sb);
      default: of_o = 1'b0;
    endcase
  end

  assign zf_o = (r_o == '0);
  assign sf_o = sr;

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage: computes valE = valB OP valA, maintains the ZF/SF/OF
// condition-code register, evaluates the branch condition against the CC value
// seen before this instruction's own update, and holds the result in a single
// output register handed to the memory stage over valid/ready.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   flush                  : drop incoming transfer and held output
//   in_valid / in_ready    : decode-side handshake
//   in_alufun, in_cfun     : ALU operation, condition to evaluate
//   in_set_cc              : instruction updates the CC register
//   in_vala, in_valb       : operands
//   in_dst                 : destination register ID (passed through)
//   out_valid / out_ready  : memory-side handshake
//   out_vale, out_cnd      : result and condition outcome
//   out_dst                : passed-through destination
//   cc_zf, cc_sf, cc_of    : current condition-code register
module alu_execute_stage
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_alufun,
  input  logic [2:0]       in_cfun,
  input  logic             in_set_cc,
  input  logic [W-1:0]     in_vala,
  input  logic [W-1:0]     in_valb,
  input  logic [DST_W-1:0] in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_vale,
  output logic             out_cnd,
  output logic [DST_W-1:0] out_dst,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  logic             valid_q, valid_d;
  logic [W-1:0]     vale_q, vale_d;
  logic             cnd_q, cnd_d;
  logic [DST_W-1:0] dst_q, dst_d;
  cc_t              cc_q, cc_d;

  logic [W-1:0] alu_r;
  logic         alu_zf, alu_sf, alu_of;
  logic         accept;

  alu_core_comb u_alu (
    .op_i (alu_op_e'(in_alufun)),
    .a_i  (in_vala),
    .b_i  (in_valb),
    .r_o  (alu_r),
    .zf_o (alu_zf),
    .sf_o (alu_sf),
    .of_o (alu_of)
  );

  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d = valid_q;
    vale_d  = vale_q;
    cnd_d   = cnd_q;
    dst_d   = dst_q;
    cc_d    = cc_q;
    if (accept) begin
      valid_d = 1'b1;
      vale_d  = alu_r;
      // Uses cc_q, i.e. the flags before this instruction updates them.
      cnd_d   = eval_cond(cond_e'(in_cfun), cc_q);
      dst_d   = in_dst;
    end else if (out_ready || flush) begin
      valid_d = 1'b0;
    end
    if (accept && in_set_cc) begin
      cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      vale_q  <= '0;
      cnd_q   <= 1'b0;
      dst_q   <= '0;
      cc_q    <= CcReset;
    end else begin
      valid_q <= valid_d;
      vale_q  <= vale_d;
      cnd_q   <= cnd_d;
      dst_q   <= dst_d;
      cc_q    <= cc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_vale  = vale_q;
  assign out_cnd   = cnd_q;
  assign out_dst   = dst_q;
  assign cc_zf     = cc_q.zf;
  assign cc_sf     = cc_q.sf;
  assign cc_of     = cc_q.of;

endmodule

// File: tb/tb_alu_execute_stage.sv
module tb_alu_execute_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_set_cc;
  logic [1:0]  in_alufun;
  logic [2:0]  in_cfun;
  logic [63:0] in_vala, in_valb, out_vale;
  logic [3:0]  in_dst, out_dst;
  logic        out_valid, out_ready, out_cnd;
  logic        cc_zf, cc_sf, cc_of;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_execute_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_alufun (in_alufun),
    .in_cfun   (in_cfun),
    .in_set_cc (in_set_cc),
    .in_vala   (in_vala),
    .in_valb   (in_valb),
    .in_dst    (in_dst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vale  (out_vale),
    .out_cnd   (out_cnd),
    .out_dst   (out_dst),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] vale;
    logic        cnd;
    logic [3:0]  dst;
  } res_t;

  // Arithmetic done on 65-bit signed integers: overflow means the exact sum
  // does not fit the 64-bit signed range.
  function automatic logic [63:0] ref_alu(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, output logic of);
    logic signed [64:0] wide;
    logic signed [64:0] lo, hi;
    lo = -(65'sd1 <<< 63);
    hi = (65'sd1 <<< 63) - 65'sd1;
    of = 1'b0;
    case (op)
      2'd0: begin
        wide = $signed({b[63], b}) + $signed({a[63], a});
        of = (wide < lo) || (wide > hi);
        return wide[63:0];
      end
      2'd1: begin
        wide = $signed({b[63], b}) - $signed({a[63], a});
        of = (wide < lo) || (wide > hi);
        return wide[63:0];
      end
      2'd2: return b & a;
      default: return b ^ a;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (c)
      3'd0: return 1'b1;
      3'd1: return (sf != of) || zf;
      3'd2: return sf != of;
      3'd3: return zf;
      3'd4: return !zf;
      3'd5: return sf == of;
      3'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  fn;
    logic [2:0]  cf;
    logic        setcc;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_vale;
    logic        exp_cnd;
    logic [2:0]  exp_cc;   // {zf, sf, of} after the instruction
  } vec_t;

  vec_t vecs[10];

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_set_cc = 0; in_alufun = 0; in_cfun = 0;
    in_vala = 0; in_valb = 0; in_dst = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  res_t        sb_q[$];
  logic [2:0]  m_cc;
  res_t        r;
  logic        m_of, acc;
  logic [63:0] m_r;
  logic [63:0] held_vale;
  logic [3:0]  held_dst;
  int          seen;
  logic [63:0] bp_exp[$];

  initial begin
    rst = 1; idle_inputs();

    // 1: reset held two cycles with in_valid high
    in_valid = 1; in_vala = 64'h11; in_valb = 64'h22; in_set_cc = 1;
    tick(); tick();
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_cc", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    chk("reset_vale", out_vale, 64'd0);
    rst = 0; in_valid = 0; #1;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // 2/3/6: back-to-back table, each result checked one cycle after issue
    vecs[0] = '{2'd0, 3'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 3'b011};
    vecs[1] = '{2'd1, 3'd1, 1'b1, 64'd5, 64'd5, 64'd0, 1'b0, 3'b100};
    vecs[2] = '{2'd3, 3'd3, 1'b0, 64'd9, 64'd9, 64'd0, 1'b1, 3'b100};
    vecs[3] = '{2'd1, 3'd4, 1'b1, 64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b010};
    vecs[4] = '{2'd2, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000, 1'b0, 3'b010};
    vecs[5] = '{2'd0, 3'd2, 1'b0, 64'd1, 64'd2, 64'd3, 1'b1, 3'b010};
    vecs[6] = '{2'd1, 3'd5, 1'b1, 64'd1, 64'h8000_0000_0000_0000,
                64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001};
    vecs[7] = '{2'd0, 3'd6, 1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 3'b100};
    vecs[8] = '{2'd3, 3'd7, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b100};
    vecs[9] = '{2'd2, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 3'b100};

    for (int i = 0; i < 10; i++) begin
      in_valid = 1; out_ready = 1;
      in_alufun = vecs[i].fn; in_cfun = vecs[i].cf; in_set_cc = vecs[i].setcc;
      in_vala = vecs[i].a; in_valb = vecs[i].b; in_dst = 4'(i);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_vale", i), out_vale, vecs[i].exp_vale);
      chk($sformatf("vec%0d_cnd", i), {63'd0, out_cnd}, {63'd0, vecs[i].exp_cnd});
      chk($sformatf("vec%0d_dst", i), {60'd0, out_dst}, {60'd0, 4'(i)});
      chk($sformatf("vec%0d_cc", i), {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, vecs[i].exp_cc});
    end
    in_valid = 0; tick();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // 4: backpressure, three cycles with out_ready low
    do_reset();
    out_ready = 0; in_valid = 1; in_alufun = 0; in_set_cc = 0; in_cfun = 0;
    in_vala = 64'd100; in_valb = 64'd1; in_dst = 4'd1;
    tick();
    held_vale = out_vale; held_dst = out_dst;
    chk("bp_first_vale", out_vale, 64'd101);
    for (int k = 0; k < 3; k++) begin
      in_vala = 64'd200 + 64'(k); in_dst = 4'(k + 2);
      #1;
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      tick();
      chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
      chk("bp_vale_stable", out_vale, held_vale);
      chk("bp_dst_stable", {60'd0, out_dst}, {60'd0, held_dst});
    end
    // release: stream distinct values, expect each exactly once, in order
    out_ready = 1;
    bp_exp = {64'd101};
    for (int k = 0; k < 4; k++) begin
      in_vala = 64'd300 + 64'(k);
      bp_exp.push_back(64'd301 + 64'(k));
      #1;
      chk("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
      chk("bp_stream_vale", out_vale, bp_exp.pop_front());
      tick();
    end
    in_valid = 0;
    chk("bp_stream_last", out_vale, bp_exp.pop_front());
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // 5: flush with a live output and an incoming set_cc instruction
    do_reset();
    in_valid = 1; out_ready = 0; in_alufun = 0; in_set_cc = 0;
    in_vala = 64'd7; in_valb = 64'd8;
    tick();
    chk("flush_pre_valid", {63'd0, out_valid}, 64'd1);
    flush = 1; in_set_cc = 1; in_alufun = 1; in_vala = 64'd3; in_valb = 64'd3;
    tick();
    flush = 0; in_valid = 0;
    chk("flush_valid_cleared", {63'd0, out_valid}, 64'd0);
    chk("flush_cc_unchanged", {61'd0, cc_zf, cc_sf, cc_of}, 64'b100);
    tick();
    chk("flush_stays_empty", {63'd0, out_valid}, 64'd0);

    // randomized traffic against a scoreboard model
    idle_inputs();
    do_reset();
    m_cc = 3'b100;
    sb_q.delete();
    seen = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      in_alufun = 2'($urandom_range(0, 3));
      in_cfun   = 3'($urandom_range(0, 7));
      in_set_cc = ($urandom_range(0, 3) != 0);
      in_dst    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin in_vala = {$urandom, $urandom}; in_valb = {$urandom, $urandom}; end
        1: begin in_vala = 64'($urandom_range(0, 5)); in_valb = 64'($urandom_range(0, 5)); end
        2: begin in_vala = {$urandom, $urandom}; in_valb = in_vala; end
        default: begin
          in_vala = {1'b0, 63'($urandom)} ^ 64'h7FFF_FFFF_0000_0000;
          in_valb = {$urandom_range(0, 1) == 1, 63'h7FFF_FFFF_FFFF_FFF0};
        end
      endcase
      #1;
      chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
      chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, (sb_q.size() == 0) || out_ready});
      chk("rnd_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_cc});
      if (sb_q.size() != 0) begin
        chk("rnd_vale", out_vale, sb_q[0].vale);
        chk("rnd_cnd", {63'd0, out_cnd}, {63'd0, sb_q[0].cnd});
        chk("rnd_dst", {60'd0, out_dst}, {60'd0, sb_q[0].dst});
      end
      // model update for the coming edge
      acc = in_valid && ((sb_q.size() == 0) || out_ready) && !flush;
      if (sb_q.size() != 0 && (out_ready || flush)) begin
        void'(sb_q.pop_front());
        seen++;
      end
      if (acc) begin
        m_r = ref_alu(in_alufun, in_vala, in_valb, m_of);
        r.vale = m_r;
        r.cnd  = ref_cond(in_cfun, m_cc);
        r.dst  = in_dst;
        sb_q.push_back(r);
        if (in_set_cc) m_cc = {m_r == 64'd0, m_r[63], m_of};
      end
      tick();
    end
    chk("rnd_traffic_seen", {63'd0, seen > 50}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
